// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream: streaming Hamming [7,4] encoder, one byte in -> two codewords out
module hamming_encoder_stream #(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [6:0]       inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_codeword,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count
);
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;
  state_t state, state_nx;
  logic [7:0] byte_q;
  logic [6:0] mask_q;
  logic accept, fire;
  function automatic logic [6:0] enc(input logic [3:0] n);
    return {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
  endfunction
  assign out_valid = state != S_IDLE;
  assign out_last = state == S_SECOND;
  assign in_ready = !rst && (state == S_IDLE || (state == S_SECOND && out_ready));
  assign accept = in_valid && in_ready;
  assign fire = out_valid && out_ready;
  // out_last flips the nibble choice, so LOW_FIRST just inverts which half leads
  assign out_codeword = enc((out_last ^ LOW_FIRST) ? byte_q[3:0] : byte_q[7:4]) ^ mask_q;
  always_comb begin
    state_nx = state;
    state_nx = (state == S_IDLE)  ? (accept ? S_FIRST : S_IDLE) :
               (state == S_FIRST) ? (fire ? S_SECOND : S_FIRST) :
               fire ? (in_valid ? S_FIRST : S_IDLE) : S_SECOND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_q   <= '0;
      mask_q   <= '0;
      cw_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        byte_q <= in_data;
        mask_q <= inj_mask;
      end
      if (fire) cw_count <= cw_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb_hamming_encoder_stream: directed and randomized checks of the encoder against a position-based Hamming model
module tb_hamming_encoder_stream;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [6:0] inj_mask = '0;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [6:0] cw_a, cw_b;
  logic [15:0] cw_count_a;
  logic [3:0] cw_count_b;
  int n_checks = 0, n_fail = 0, cnt = 0;
  logic [6:0] qa[$], qb[$];
  logic hold_pend = 1'b0;
  logic [6:0] held_a, held_b;

  hamming_encoder_stream #(.LOW_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .inj_mask(inj_mask), .out_valid(out_valid_a), .out_ready(out_ready), .out_codeword(cw_a),
    .out_last(out_last_a), .cw_count(cw_count_a));
  hamming_encoder_stream #(.LOW_FIRST(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .inj_mask(inj_mask), .out_valid(out_valid_b), .out_ready(out_ready), .out_codeword(cw_b),
    .out_last(out_last_b), .cw_count(cw_count_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of w is the Hamming position; parity at 2^k covers every position with bit k set
  function automatic logic [6:0] enc_ref(input logic [3:0] n);
    logic [7:0] w;
    logic par;
    w = '0;
    w[3] = n[0]; w[5] = n[1]; w[6] = n[2]; w[7] = n[3];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int p = 3; p < 8; p++) if ((p & (1 << k)) != 0) par ^= w[p];
      w[1 << k] = par;
    end
    return w[7:1];
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic [2:0] s;
    s = '0;
    for (int p = 1; p < 8; p++) if (cw[p-1]) s ^= 3'(p);
    return s;
  endfunction

  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = !rst && (qa.size() == 0 || (qa.size() == 1 && out_ready));
    chk("in_ready_a", 16'(in_ready_a), 16'(exp_rdy));
    chk("in_ready_b", 16'(in_ready_b), 16'(exp_rdy));
    chk("valid_a", 16'(out_valid_a), 16'(qa.size() != 0));
    chk("valid_b", 16'(out_valid_b), 16'(qb.size() != 0));
    chk("last_a", 16'(out_last_a), 16'(qa.size() == 1));
    chk("last_b", 16'(out_last_b), 16'(qb.size() == 1));
    chk("count_a", cw_count_a, 16'(cnt % 65536));
    chk("count_b", 16'(cw_count_b), 16'(cnt % 16));
    if (qa.size() != 0) begin
      chk("cw_a", 16'(cw_a), 16'(qa[0]));
      chk("cw_b", 16'(cw_b), 16'(qb[0]));
    end
    if (hold_pend) begin
      chk("hold_a", 16'(cw_a), 16'(held_a));
      chk("hold_b", 16'(cw_b), 16'(held_b));
    end
    hold_pend = !rst && qa.size() != 0 && !out_ready;
    held_a = cw_a;
    held_b = cw_b;
    if (rst) begin
      qa.delete(); qb.delete(); cnt = 0;
    end else begin
      if (qa.size() != 0 && out_ready) begin
        void'(qa.pop_front()); void'(qb.pop_front()); cnt++;
      end
      if (in_valid && exp_rdy) begin
        qa.push_back(enc_ref(in_data[3:0]) ^ inj_mask); qa.push_back(enc_ref(in_data[7:4]) ^ inj_mask);
        qb.push_back(enc_ref(in_data[7:4]) ^ inj_mask); qb.push_back(enc_ref(in_data[3:0]) ^ inj_mask);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [6:0] m, output int n);
    in_valid = 1'b1; in_data = d; inj_mask = m;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready_a && n < 50);
    if (n >= 50) chk("accept_timeout", 16'(0), 16'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();
    out_ready = 1'b1;
    send(8'hB3, 7'h00, n);
    chk("t1_cw0", 16'(cw_a), 16'(7'b0011110)); chk("t1_last0", 16'(out_last_a), 16'(0));
    chk("t6_cw0", 16'(cw_b), 16'(7'b1010101));
    cyc();
    chk("t1_cw1", 16'(cw_a), 16'(7'b1010101)); chk("t1_last1", 16'(out_last_a), 16'(1));
    chk("t6_cw1", 16'(cw_b), 16'(7'b0011110));
    cyc();
    chk("t1_idle", 16'(out_valid_a), 16'(0)); chk("t1_count", cw_count_a, 16'(2));
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 7'h00, n);
      chk("t2_gap", 16'(n), 16'(i == 0 ? 1 : 2));
    end
    cyc(); cyc();
    chk("t2_count_a", cw_count_a, 16'(512)); chk("t2_count_b", 16'(cw_count_b), 16'(0));
    out_ready = 1'b0;
    send(8'hF0, 7'h00, n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_cw", 16'(cw_a), 16'(7'b0000000)); chk("t3_hold_v", 16'(out_valid_a), 16'(1));
      chk("t3_hold_rdy", 16'(in_ready_a), 16'(0));
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("t3_cw1", 16'(cw_a), 16'(7'b1111111)); chk("t3_last1", 16'(out_last_a), 16'(1));
    cyc();
    send(8'hBB, 7'b0000100, n);
    chk("t4_cw0", 16'(cw_a), 16'(7'b1010001)); chk("t4_syn0", 16'(syndrome(cw_a)), 16'(3));
    cyc();
    chk("t4_cw1", 16'(cw_a), 16'(7'b1010001)); chk("t4_syn1", 16'(syndrome(cw_a)), 16'(3));
    cyc();
    send(8'h3C, 7'h00, n);
    cyc();
    chk("t5_in_second", 16'(out_last_a), 16'(1));
    rst = 1'b1;
    cyc();
    chk("t5_valid", 16'(out_valid_a), 16'(0)); chk("t5_count", cw_count_a, 16'(0));
    rst = 1'b0;
    cyc();
    chk("t5_no_second", 16'(out_valid_a), 16'(0));
    send(8'h0F, 7'h00, n);
    chk("t5_cw0", 16'(cw_a), 16'(7'b1111111));
    cyc();
    chk("t5_cw1", 16'(cw_a), 16'(7'b0000000));
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = ($urandom % 150) == 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      inj_mask = ($urandom % 8) == 0 ? 7'($urandom) : 7'h00;
    end
    cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("drained", 16'(out_valid_a), 16'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_encoder_stream.md
Name: hamming_encoder_stream

Overview:
Streaming Hamming [7,4] encoder, the transmit-side counterpart of hamming_decoder. It accepts bytes over a valid/ready interface and splits each byte into two nibbles. Each nibble is encoded into a 7-bit codeword, and the codewords leave on a second valid/ready interface at one codeword per cycle sustained. An optional per-byte error-injection mask lets benches exercise the decoder's single-bit correction.

Parameters:
LOW_FIRST, 1, 1: emit the low nibble codeword first; 0: emit the high nibble codeword first.
CNT_W, 16, width of the emitted-codeword counter.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte available on in_data
in_ready  output  1  encoder can accept a byte this cycle
in_data  input  8  byte to encode
inj_mask  input  7  XOR mask, sampled with each accepted byte (0 = no injection)
out_valid  output  1  codeword valid on out_codeword
out_ready  input  1  downstream accepts the codeword this cycle
out_codeword  output  7  encoded codeword
out_last  output  1  high on the second codeword of a byte
cw_count  output  CNT_W  count of codewords handed off; wraps

Behaviour:
- Codeword bit i corresponds to Hamming position i+1. For nibble n[3:0] = {d4,d3,d2,d1}:
  - out_codeword = {d4,d3,d2,p3,d1,p2,p1} XOR mask
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
- FSM states:
  - S_IDLE: out_valid=0, in_ready=1. On in_valid&&in_ready, register the byte and inj_mask, then go to S_FIRST.
  - S_FIRST: out_valid=1, out_last=0, first nibble per LOW_FIRST. On out_valid&&out_ready, go to S_SECOND.
  - S_SECOND: out_valid=1, out_last=1, other nibble. in_ready=out_ready. On handshake:
    - if in_valid: register the new byte and mask, go to S_FIRST (no bubble);
    - otherwise go to S_IDLE.
- in_ready = (state==S_IDLE) || (state==S_SECOND && out_ready). in_ready is forced to 0 while rst=1. The out_ready->in_ready path is the only combinational path through the block.
- out_codeword and out_last derive only from registered state. There is no path from in_data to out_*.
- Latency: byte accepted at edge N gives the first codeword valid in cycle N+1 and the second in N+2 (out_ready=1). Sustained throughput is 2 codewords per byte, 1 per cycle.
- Hold rule: while out_valid && !out_ready, out_codeword, out_last and out_valid stay stable. out_valid never drops without a handshake (reset excepted).
- The mask applies to both codewords of its byte. A mask with more than one bit set is legal and is applied unchanged.
- cw_count increments by 1 on each out_valid&&out_ready and wraps from 2^CNT_W-1 to 0.
- Reset (synchronous; takes priority over all handshakes in the same cycle):
  - state=S_IDLE, out_valid=0, out_codeword=0, out_last=0, cw_count=0, internal byte/mask registers=0.
  - A byte in flight mid-operation is discarded; a half-sent byte's second codeword is never emitted.
- Simultaneous in_valid and handshake in S_SECOND with out_ready=0: no byte is accepted (in_ready=0) and state holds.

Test Plan:
1. Reset, LOW_FIRST=1, byte 8'hB3, out_ready=1 -> codewords 7'b0011110 (last=0) at cycle N+1, then 7'b1010101 (last=1) at N+2; cw_count=2; back to S_IDLE.
2. Bytes 8'h00..8'hFF back-to-back, in_valid and out_ready held high -> 512 codewords with no bubbles, each matching the parity equations; cw_count=512. With CNT_W=4, cw_count=0 after 16 codewords.
3. Byte 8'hF0, out_ready held low 5 cycles -> out_codeword stays 7'b0000000 with out_valid=1 and in_ready=0; after release, 7'b1111111 with last=1.
4. Byte 8'hBB with inj_mask=7'b0000100 -> both codewords 7'b1010001. Feeding them to hamming_decoder yields data 4'b1011 and syndrome 3'd3.
5. Reset asserted in S_SECOND after byte 8'h3C -> next cycle out_valid=0, cw_count=0, second codeword never appears. After rst low, byte 8'h0F gives 7'b1111111 then 7'b0000000.
6. LOW_FIRST=0, byte 8'hB3 -> 7'b1010101 (last=0), then 7'b0011110 (last=1).
